fetch_halt_ctrl: RTL

Program-counter and halt sequencer in the IF stage, directly downstream of the halting unit. Consumes the decode-stage `halt` request raised on EBREAK, freezes instruction fetch, and squashes the IF/ID slot. Waits for the older instructions in EX/MEM/WB to retire, then reports a fully drained, halted CPU. Also owns normal PC sequencing: increment, hazard stall, and branch/jump redirect.

---
 rtl/fetch_halt_ctrl.sv | 128 ++++++++++++
 1 files changed

// File: rtl/fetch_halt_ctrl.sv
// fetch_halt_ctrl
//   IF-stage program counter sequencer and halt controller. Handles PC
//   increment, load-use stall, branch/jump redirect and the EBREAK halt
//   sequence. That sequence freezes fetch, squashes IF/ID, waits for the
//   older instructions to drain, and then reports the CPU as halted.
//
//   Optional feature macro: HALT_RESUME_EN
//     When it is defined, the i_resume port exists and returns the block
//     from HALTED to RUN.
//     When it is undefined, HALTED is left only through rst_n.
//
//   DRAIN_CYCLES must lie in the range 1..15.
module fetch_halt_ctrl #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int unsigned DRAIN_CYCLES = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_halt_req,
  input  logic        i_stall,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
`ifdef HALT_RESUME_EN
  input  logic        i_resume,
`endif
  output logic [31:0] o_pc,
  output logic        o_fetch_valid,
  output logic        o_flush_if_id,
  output logic        o_draining,
  output logic        o_halted
);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_DRAIN   = 2'd1,
    ST_HALTED  = 2'd2
  } state_t;

  // The drain counter counts down to zero.
  // A load of N-1 therefore keeps the block in DRAIN for N cycles.
  localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] w_pc_nxt;
  logic [3:0]  r_cnt;
  logic [3:0]  w_cnt_nxt;
  logic        w_flush;

  // Next-state, next-PC, drain counter and IF/ID flush decision.
  always_comb begin
    // NOTE: every signal gets a default before the case statement.
    // Any path that skips an assignment then keeps its value instead of
    // inferring a latch.
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_cnt_nxt   = r_cnt;
    w_flush     = 1'b1;

    unique case (r_state)
      ST_RUN: begin
        w_flush = 1'b0;
        if (i_redirect) begin
          // A halt raised alongside a redirect comes from a wrong-path
          // instruction, so the redirect wins.
          w_pc_nxt = i_redirect_pc;
          w_flush  = 1'b1;
        end else if (i_stall) begin
          // Hold the PC. A pending halt is looked at again once the
          // stall releases.
          w_pc_nxt = r_pc;
        end else if (i_halt_req) begin
          // The PC already points at EBREAK + 4, so it simply holds.
          w_flush     = 1'b1;
          w_cnt_nxt   = DRAIN_LOAD;
          w_state_nxt = ST_DRAIN;
        end else begin
          // The PC wraps silently at 2^32.
          w_pc_nxt = r_pc + 32'd4;
        end
      end

      ST_DRAIN: begin
        if (r_cnt == 4'd0) begin
          w_state_nxt = ST_HALTED;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end

      ST_HALTED: begin
`ifdef HALT_RESUME_EN
        // Fetch restarts from the held PC (EBREAK + 4).
        if (i_resume) begin
          w_state_nxt = ST_RUN;
        end
`endif
      end

      default: begin
        w_state_nxt = ST_RUN;
      end
    endcase
  end

  // State, PC and drain counter registers. Reset is asynchronous.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_RUN;
      r_pc    <= RESET_PC;
      r_cnt   <= 4'd0;
    end else begin
      // NOTE: sequential state is updated with non-blocking assignments,
      // so every register samples values from before the clock edge.
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  assign o_pc          = r_pc;
  assign o_fetch_valid = (r_state == ST_RUN);
  assign o_draining    = (r_state == ST_DRAIN);
  assign o_halted      = (r_state == ST_HALTED);
  assign o_flush_if_id = w_flush;

endmodule
